cadence_gen: RTL and testbench



---
 rtl/cadence_gen_if.sv | 22 ++
 rtl/cadence_gen.sv | 106 ++++++++++
 tb/tb_cadence_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cadence_gen_if.sv
// Control/status bundle for the cadence sensor emulator.
// master drives the request side; slave is the generator itself.
`timescale 1ns/1ps
interface cadence_gen_if;
  logic       en;
  logic [7:0] cad_per;
  logic       bounce_en;
  logic       cadence;
  logic       cad_rise;
  logic       running;
  logic [7:0] per_latched;

  modport master (
    output en, cad_per, bounce_en,
    input  cadence, cad_rise, running, per_latched
  );

  modport slave (
    input  en, cad_per, bounce_en,
    output cadence, cad_rise, running, per_latched
  );
endinterface

// File: rtl/cadence_gen.sv
// Pedal-cadence sensor emulator: square wave with a period programmed in the
// measurement block's 8-bit units, plus optional contact-bounce glitches.
`timescale 1ns/1ps
module cadence_gen #(
  parameter int unsigned FAST_SIM = 0
) (
  input logic           clk,
  input logic           rst_n,
  cadence_gen_if.slave  bus
);

  typedef enum logic [1:0] {STOP, HIGH, LOW} state_t;

  localparam logic [7:0] NOT_PEDALING = 8'hE4;

  state_t      state, state_d;
  logic [23:0] cnt, cnt_d;
  logic [7:0]  per_q, per_d;
  logic        cadence_q, cadence_d;
  logic        rise_q, rise_d;
  logic        running_q;
  logic        per_valid;
  logic [23:0] p_cur, h_cur, h_nxt, phase_nxt;

  function automatic logic [23:0] period_of(input logic [7:0] per);
    if (FAST_SIM != 0) return {9'd0, per, 7'd0};
    else               return {per, 16'd0};
  endfunction

  assign per_valid = (bus.cad_per != 8'h00) && (bus.cad_per < NOT_PEDALING);
  assign p_cur     = period_of(per_q);
  assign h_cur     = p_cur >> 1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    per_d   = per_q;
    rise_d  = 1'b0;
    case (state)
      STOP: begin
        if (bus.en && per_valid) begin
          state_d = HIGH;
          cnt_d   = '0;
          per_d   = bus.cad_per;
          rise_d  = 1'b1;
        end
      end
      HIGH: begin
        cnt_d = cnt + 24'd1;
        if (cnt == h_cur - 24'd1) state_d = LOW;
      end
      LOW: begin
        if (cnt == p_cur - 24'd1) begin
          cnt_d = '0;
          if (bus.en && per_valid) begin
            state_d = HIGH;
            per_d   = bus.cad_per;
            rise_d  = 1'b1;
          end else begin
            state_d = STOP;
            per_d   = NOT_PEDALING;
          end
        end else begin
          cnt_d = cnt + 24'd1;
        end
      end
      default: state_d = STOP;
    endcase
  end

  // Outputs are registered from next-state values so cadence tracks the
  // state it belongs to; bounce phase is taken relative to the half it sits in.
  assign h_nxt     = period_of(per_d) >> 1;
  assign phase_nxt = (state_d == LOW) ? (cnt_d - h_nxt) : cnt_d;

  always_comb begin
    cadence_d = (state_d == HIGH);
    if (bus.bounce_en && (state_d != STOP) &&
        ((phase_nxt == 24'd2) || (phase_nxt == 24'd5)))
      cadence_d = ~cadence_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      cnt       <= '0;
      per_q     <= NOT_PEDALING;
      cadence_q <= 1'b0;
      rise_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      per_q     <= per_d;
      cadence_q <= cadence_d;
      rise_q    <= rise_d;
      running_q <= (state_d != STOP);
    end
  end

  assign bus.cadence     = cadence_q;
  assign bus.cad_rise    = rise_q;
  assign bus.running     = running_q;
  assign bus.per_latched = per_q;

endmodule

// File: tb/tb_cadence_gen.sv
// Self-checking bench for cadence_gen (FAST_SIM=1): vector table, directed
// sequences, and a per-period scoreboard fed by the stimulus side.
`timescale 1ns/1ps
module tb_cadence_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cadence_gen_if bus();

  cadence_gen #(.FAST_SIM(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         period;
    int         high;
    logic [7:0] per;
  } per_exp_t;

  typedef struct {
    logic       en;
    logic [7:0] cad_per;
    logic       starts;
  } vec_t;

  per_exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // FAST_SIM=1: one LSB of cad_per is 128 clocks, high half is 64 per LSB
  function automatic void expect_period(input logic [7:0] per);
    per_exp_t e;
    e.period = int'(per) * 128;
    e.high   = int'(per) * 64;
    e.per    = per;
    sbq.push_back(e);
  endfunction

  // Period monitor: a period runs from one cad_rise to the next cad_rise or
  // to running dropping; its length, high count and latched value are scored.
  bit         mon_active = 1'b0;
  int         mon_cyc    = 0;
  int         mon_hi     = 0;
  logic [7:0] mon_per    = 8'h00;

  always @(negedge clk) begin : monitor
    per_exp_t e;
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (mon_active && (bus.cad_rise || !bus.running)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_period", mon_cyc, 0);
        end else begin
          e = sbq.pop_front();
          chk("period_len", mon_cyc, e.period);
          chk("high_len", mon_hi, e.high);
          chk("period_per", int'(mon_per), int'(e.per));
        end
        mon_active = 1'b0;
      end
      if (bus.cad_rise) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_hi     = 0;
        mon_per    = bus.per_latched;
      end
      if (mon_active) begin
        mon_cyc++;
        if (bus.cadence) mon_hi++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int limit, input string name, output int waited);
    waited = limit;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (bus.cad_rise) begin
        waited = i + 1;
        break;
      end
    end
    if (waited == limit && !bus.cad_rise) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_stop(input int limit, input string name, output int waited);
    waited = limit;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (!bus.running) begin
        waited = i + 1;
        break;
      end
    end
    if (waited == limit && bus.running) chk({name, "_timeout"}, 0, 1);
  endtask

  vec_t vecs[6];

  initial begin : stim
    int  w;
    int  exp_cad;
    vecs[0] = '{1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'hE4, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 8'h10, 1'b0};
    vecs[4] = '{1'b1, 8'h01, 1'b1};
    vecs[5] = '{1'b1, 8'hE3, 1'b1};

    bus.en        = 1'b0;
    bus.cad_per   = 8'h00;
    bus.bounce_en = 1'b0;

    // reset state
    #23;
    chk("rst_cadence", int'(bus.cadence), 0);
    chk("rst_cad_rise", int'(bus.cad_rise), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_per", int'(bus.per_latched), 'hE4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    chk("idle_running", int'(bus.running), 0);
    chk("idle_per", int'(bus.per_latched), 'hE4);

    // vector table: start / no-start from STOP, one period then en drop
    for (int i = 0; i < 6; i++) begin
      bus.en      = vecs[i].en;
      bus.cad_per = vecs[i].cad_per;
      if (vecs[i].starts) expect_period(vecs[i].cad_per);
      tick(1);
      chk($sformatf("v%0d_running", i), int'(bus.running), int'(vecs[i].starts));
      chk($sformatf("v%0d_cadence", i), int'(bus.cadence), int'(vecs[i].starts));
      chk($sformatf("v%0d_rise", i), int'(bus.cad_rise), int'(vecs[i].starts));
      chk($sformatf("v%0d_per", i), int'(bus.per_latched),
          vecs[i].starts ? int'(vecs[i].cad_per) : 'hE4);
      tick(1);
      chk($sformatf("v%0d_rise_1clk", i), int'(bus.cad_rise), 0);
      chk($sformatf("v%0d_running2", i), int'(bus.running), int'(vecs[i].starts));
      bus.en = 1'b0;
      if (vecs[i].starts) begin
        wait_stop(40000, $sformatf("v%0d_stop", i), w);
        chk($sformatf("v%0d_stop_per", i), int'(bus.per_latched), 'hE4);
        chk($sformatf("v%0d_stop_cadence", i), int'(bus.cadence), 0);
      end
    end

    // period change mid-period takes effect only at the boundary
    bus.cad_per = 8'h10;
    bus.en      = 1'b1;
    expect_period(8'h10);
    tick(1);
    chk("pc_rise", int'(bus.cad_rise), 1);
    tick(500);
    bus.cad_per = 8'h08;
    expect_period(8'h08);
    tick(1);
    chk("pc_per_mid", int'(bus.per_latched), 'h10);
    wait_rise(4000, "pc_rise2", w);
    chk("pc_remaining1", w, 2048 - 501);
    chk("pc_per_new", int'(bus.per_latched), 'h08);
    tick(500);
    bus.cad_per = 8'h10;
    expect_period(8'h10);
    wait_rise(4000, "pc_rise3", w);
    chk("pc_remaining2", w, 1024 - 500);
    chk("pc_per_back", int'(bus.per_latched), 'h10);

    // en drop in the low half: period completes, no extra pulse
    tick(1500);
    chk("drop_cad_low", int'(bus.cadence), 0);
    bus.en = 1'b0;
    wait_stop(4000, "drop_stop", w);
    chk("drop_remaining", w, 548);
    chk("drop_per", int'(bus.per_latched), 'hE4);
    chk("drop_cadence", int'(bus.cadence), 0);
    tick(3);
    chk("drop_still_stop", int'(bus.running), 0);

    // bounce glitches at phase 2 and 5 of each half, shortest period
    bus.bounce_en = 1'b1;
    bus.cad_per   = 8'h01;
    bus.en        = 1'b1;
    expect_period(8'h01);
    tick(1);
    bus.en = 1'b0;
    for (int c = 0; c < 128; c++) begin
      exp_cad = (c < 64) ? 1 : 0;
      if (c == 2 || c == 5 || c == 66 || c == 69) exp_cad = 1 - exp_cad;
      chk($sformatf("bnc_cad_c%0d", c), int'(bus.cadence), exp_cad);
      chk($sformatf("bnc_rise_c%0d", c), int'(bus.cad_rise), (c == 0) ? 1 : 0);
      tick(1);
    end
    chk("bnc_stopped", int'(bus.running), 0);
    bus.bounce_en = 1'b0;

    // asynchronous reset mid-HIGH, then restart one clock after release
    bus.cad_per = 8'h10;
    bus.en      = 1'b1;
    tick(1);
    tick(100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cadence", int'(bus.cadence), 0);
    chk("arst_running", int'(bus.running), 0);
    chk("arst_per", int'(bus.per_latched), 'hE4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_period(8'h10);
    tick(1);
    chk("arst_rise", int'(bus.cad_rise), 1);
    chk("arst_cad_up", int'(bus.cadence), 1);
    chk("arst_per_new", int'(bus.per_latched), 'h10);
    bus.en = 1'b0;
    wait_stop(4000, "arst_stop", w);
    chk("arst_final_per", int'(bus.per_latched), 'hE4);

    tick(2);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
